// File: rtl/hpdl_pkg.sv
// Shared types and constants for the HPDL-1414 frame writer: FSM state
// encoding, glyph range limits, the blank glyph and the default caret glyph.
package hpdl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_SETUP  = 3'd3,
    ST_STROBE = 3'd4,
    ST_HOLD   = 3'd5
  } state_t;

  localparam logic [6:0] HPDL_SPACE      = 7'h20;
  localparam logic [6:0] CURSOR_CHAR_DEF = 7'h5F;

  // Directly displayable range and the lower-case range folded onto it.
  localparam logic [7:0] GLYPH_LO = 8'h20;
  localparam logic [7:0] GLYPH_HI = 8'h5F;
  localparam logic [7:0] LOWER_LO = 8'h60;
  localparam logic [7:0] LOWER_HI = 8'h7F;
  localparam logic [6:0] CASE_OFS = 7'h20;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/hpdl_char_map.sv
// ASCII byte to HPDL-1414 glyph code. The display only has 0x20..0x5F, so
// lower case is folded to upper case and everything else becomes a blank.
module hpdl_char_map
  import hpdl_pkg::*;
(
  input  logic [7:0] i_char,
  output logic [6:0] o_glyph
);

  // Range-based remap of one character.
  always_comb begin
    o_glyph = HPDL_SPACE;
    if (i_char >= GLYPH_LO && i_char <= GLYPH_HI) begin
      o_glyph = i_char[6:0];
    end else if (i_char >= LOWER_LO && i_char <= LOWER_HI) begin
      o_glyph = i_char[6:0] - CASE_OFS;
    end else begin
      o_glyph = HPDL_SPACE;
    end
  end

endmodule

// File: rtl/hpdl_frame_writer.sv
// Scans the 16-character framebuffer and writes it to four HPDL-1414 displays
// with explicit setup / strobe / hold cycle counts. A frame is written only
// when a refresh is pending (after reset, on i_refresh, or on caret events).
// Optional feature macro: CARET_BLINK_EN (blinking caret overlay).
module hpdl_frame_writer
  import hpdl_pkg::*;
#(
  parameter int unsigned T_SETUP     = 2,
  parameter int unsigned T_WR        = 2,
  parameter int unsigned T_HOLD      = 1,
  parameter int unsigned BLINK_HALF  = 4194304,
  parameter logic [6:0]  CURSOR_CHAR = CURSOR_CHAR_DEF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       i_refresh,
  output logic [3:0] o_rd_addr,
  input  logic [7:0] i_rd_data,
  input  logic [3:0] i_caret_pos,
  output logic [6:0] HPDL_D,
  output logic [1:0] HPDL_A,
  output logic [3:0] HPDL_WR_N,
  output logic       o_busy
);

  localparam int unsigned T_MAX = max3(T_SETUP, T_WR, T_HOLD);
  localparam int unsigned CNT_W = $clog2(T_MAX) + 1;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] WR_LAST    = CNT_W'(T_WR - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(T_HOLD - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_idx;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pending;
  logic [3:0]       r_rd_addr;
  logic [6:0]       r_d;
  logic [1:0]       r_a;
  logic [3:0]       r_wr_n;
  logic             r_busy;
  logic [6:0]       w_glyph;
  logic [6:0]       w_load_glyph;
  logic             w_extra_pending;
  logic             w_take;

  hpdl_char_map u_char_map (
    .i_char  (i_rd_data),
    .o_glyph (w_glyph)
  );

`ifdef CARET_BLINK_EN
  logic [31:0] r_blink_cnt;
  logic        r_phase;
  logic [3:0]  r_caret_q;
  logic        w_blink_tgl;

  assign w_blink_tgl     = (r_blink_cnt == BLINK_HALF - 32'd1);
  assign w_extra_pending = w_blink_tgl | (i_caret_pos != r_caret_q);
  assign w_load_glyph    = (r_phase && (r_idx == i_caret_pos)) ? CURSOR_CHAR : w_glyph;

  // Free-running blink timebase and caret-position change tracking.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_blink_cnt <= 32'd0;
      r_phase     <= 1'b0;
      r_caret_q   <= i_caret_pos;
    end else begin
      r_caret_q <= i_caret_pos;
      if (w_blink_tgl) begin
        r_blink_cnt <= 32'd0;
        r_phase     <= ~r_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + 32'd1;
      end
    end
  end
`else
  logic w_unused_cfg;
  assign w_unused_cfg    = ^{i_caret_pos, BLINK_HALF[0], CURSOR_CHAR};
  assign w_extra_pending = 1'b0;
  assign w_load_glyph    = w_glyph;
`endif

  assign w_take = (r_state == ST_IDLE) && r_pending;

  // Next-state decode; timed phases end when the shared counter hits its limit.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (r_pending) w_state_nxt = ST_FETCH; else w_state_nxt = ST_IDLE;
      ST_FETCH:  w_state_nxt = ST_LOAD;
      ST_LOAD:   w_state_nxt = ST_SETUP;
      ST_SETUP:  if (r_cnt == SETUP_LAST) w_state_nxt = ST_STROBE; else w_state_nxt = ST_SETUP;
      ST_STROBE: if (r_cnt == WR_LAST) w_state_nxt = ST_HOLD; else w_state_nxt = ST_STROBE;
      ST_HOLD: begin
        if (r_cnt == HOLD_LAST) begin
          if (r_idx == 4'd15) w_state_nxt = ST_IDLE; else w_state_nxt = ST_FETCH;
        end else begin
          w_state_nxt = ST_HOLD;
        end
      end
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // State register and shared phase counter (restarts on every state change).
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt != r_state) r_cnt <= '0;
      else                        r_cnt <= r_cnt + CNT_ONE;
    end
  end

  // Refresh request latch: new requests win over the IDLE consume so none is lost.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pending <= 1'b1;
    end else if (i_refresh || w_extra_pending) begin
      r_pending <= 1'b1;
    end else if (w_take) begin
      r_pending <= 1'b0;
    end else begin
      r_pending <= r_pending;
    end
  end

  // Registered display bus, strobes, read address, character index and busy flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_idx     <= 4'd0;
      r_rd_addr <= 4'd0;
      r_d       <= HPDL_SPACE;
      r_a       <= 2'd0;
      r_wr_n    <= 4'hF;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_pending) begin
            r_idx     <= 4'd0;
            r_rd_addr <= 4'd0;
            r_busy    <= 1'b1;
          end
        end
        ST_LOAD: begin
          r_d <= w_load_glyph;
          r_a <= ~r_idx[1:0];
        end
        ST_SETUP: begin
          if (w_state_nxt == ST_STROBE) r_wr_n <= ~(4'b0001 << r_idx[3:2]);
        end
        ST_STROBE: begin
          if (w_state_nxt == ST_HOLD) r_wr_n <= 4'hF;
        end
        ST_HOLD: begin
          if (w_state_nxt == ST_FETCH) begin
            r_idx     <= r_idx + 4'd1;
            r_rd_addr <= r_idx + 4'd1;
          end else if (w_state_nxt == ST_IDLE) begin
            r_busy <= 1'b0;
          end
        end
        default: begin
          r_wr_n <= 4'hF;
        end
      endcase
    end
  end

  assign o_rd_addr = r_rd_addr;
  assign HPDL_D    = r_d;
  assign HPDL_A    = r_a;
  assign HPDL_WR_N = r_wr_n;
  assign o_busy    = r_busy;

endmodule
